data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port DataMemory between two requesters: port C (CPU datapath) and port D (debug/loader).
//  Sits between the CPU's memory control signals and DataMemory. Owns the memory control lines.
//  Serialises accesses through a small FSM, resolves conflicts and returns read data to the owning port.
// PARAMETERS
//  ADDR_W  6  data-memory address width
//  DATA_W  8  data word width
//  CNT_W   8  width of the conflict counter
// PORTS
//  clk           in   1       single clock, rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  c_req/d_req   in   1       access request; held with we/addr/wdata until gnt
//  c_we/d_we     in   1       1=write, 0=read
//  c_addr/d_addr in   ADDR_W  access address
//  c_wdata/d_wdata in DATA_W  write data
//  c_gnt/d_gnt   out  1       1-cycle pulse; request accepted, requester may change inputs next cycle
//  c_rvalid/d_rvalid out 1    1-cycle pulse; rdata valid
//  c_rdata/d_rdata out DATA_W read data; holds last value until the next rvalid for that port
//  mem_read      out  1       to DataMemory
//  mem_write     out  1       to DataMemory
//  mem_addr      out  ADDR_W  to DataMemory
//  mem_wdata     out  DATA_W  to DataMemory data_in
//  mem_rdata     in   DATA_W  from DataMemory data_out; valid the cycle after mem_read
//  busy          out  1       FSM not in IDLE
//  conflict_cnt  out  CNT_W   saturating count of arbitration losses
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM=IDLE, last_win=D; all outputs 0, including rdata and conflict_cnt.
//  All outputs are registered.
//  FSM states: IDLE, ACCESS, RDWAIT.
//  IDLE:
//   - On a clock edge with any req=1: pick a winner; latch its we/addr/wdata into mem_* registers.
//   - Assert winner gnt and mem_read=~we or mem_write=we; go to ACCESS.
//   - Otherwise stay in IDLE.
//  ACCESS (exactly 1 cycle): gnt and mem_read/mem_write high for this cycle only.
//   - write: next state IDLE.
//   - read: next state RDWAIT.
//  RDWAIT (1 cycle): at its closing edge, owner rdata<=mem_rdata and owner rvalid<=1 (for 1 cycle); next state IDLE.
//  Latency from the edge req is sampled:
//   - gnt/mem strobe visible 1 cycle later.
//   - rvalid 3 cycles later.
//   - Minimum spacing: 2 cycles per write, 3 cycles per read.
//  req is sampled only in IDLE.
//   - A request arriving during ACCESS/RDWAIT waits.
//   - A request withdrawn before sampling is never served.
//  mem_addr/mem_wdata keep their last value outside ACCESS; mem_read/mem_write are 0 outside ACCESS.
//  Both req=1 in IDLE = conflict:
//   - winner per CONFIGURATION; last_win<=winner.
//   - conflict_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
//  Single request: always granted; last_win updated; conflict_cnt unchanged.
//  Read-after-write to the same address from different ports: ordered by grant order; the read returns the new value.
//  rvalid of one access may coincide with the IDLE sampling edge of the next access; both happen.
//  Reset mid-operation returns to IDLE immediately; a pending read produces no rvalid.
//  Requester contract: inputs stable while req=1 and gnt=0; violations are not detected.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - On conflict, winner = port other than last_win.
//   - Guarantees each port waits at most one foreign access.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, port C always wins conflicts; port D may starve.
// TESTING
//  1 Reset: reset_n=0 mid-RDWAIT -> all outputs 0 asynchronously, no rvalid after release, busy=0.
//  2 Write then read: D write addr 6'h05 data 8'hA5; C read 6'h05
//    -> mem_write 1 cycle after sample; c_rvalid with c_rdata=8'hA5 3 cycles after its sample.
//  3 Conflict, RR build: both req reads each time, held continuously
//    -> grants alternate C,D,C,D (last_win=D after reset); conflict_cnt=4 after 4 grants.
//  4 Conflict, fixed build: both req held for 3 C reads -> three c_gnt before any d_gnt; conflict_cnt=3.
//  5 Saturation: force 300 conflicts with CNT_W=8 -> conflict_cnt stays 8'hFF.
//  6 Late request: d_req rises during C's ACCESS -> d_gnt no earlier than 1 cycle after FSM returns to IDLE;
//    c_rdata unchanged by D's access.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port data memory between port C (CPU) and port D (debug/loader).
// Build option ARB_ROUND_ROBIN_EN: round-robin on conflict; undefined = fixed priority to port C.
module data_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t            state;
  logic              last_win;  // 0 = C, 1 = D
  logic              owner;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              conflict;

  always_comb begin
    conflict = c_req && d_req;
    if (conflict) win = RR_EN ? ~last_win : 1'b0;
    else          win = ~c_req;
    win_we    = win ? d_we    : c_we;
    win_addr  = win ? d_addr  : c_addr;
    win_wdata = win ? d_wdata : c_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_win     <= 1'b1;
      owner        <= 1'b0;
      c_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      c_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      c_rdata      <= '0;
      d_rdata      <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      c_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            owner     <= win;
            last_win  <= win;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_read  <= ~win_we;
            mem_write <= win_we;
            c_gnt     <= ~win;
            d_gnt     <= win;
            busy      <= 1'b1;
            state     <= ACCESS;
            if (conflict && conflict_cnt != {CNT_W{1'b1}})
              conflict_cnt <= conflict_cnt + CNT_W'(1);
          end
        end
        ACCESS: begin
          // mem_read is still high this cycle only for a read access
          if (mem_read) begin
            state <= RDWAIT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RDWAIT: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (owner) begin
            d_rdata  <= mem_rdata;
            d_rvalid <= 1'b1;
          end else begin
            c_rdata  <= mem_rdata;
            c_rvalid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: transaction-level reference model with per-cycle compare,
// plus directed scenarios with literal expectations. Honours ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;
  logic       clk;
  logic       reset_n;
  logic       c_req, c_we, d_req, d_we;
  logic [5:0] c_addr, d_addr;
  logic [7:0] c_wdata, d_wdata;
  logic       c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [7:0] c_rdata, d_rdata;
  logic       mem_read, mem_write, busy;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] conflict_cnt;

  data_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Single-port memory behind the arbiter: registered read data.
  logic [7:0] bmem [64];
  initial begin
    for (int i = 0; i < 64; i++) bmem[i] = 8'(i * 7 + 3);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_write) bmem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= bmem[mem_addr];
    end
  end

  // Reference model: each accepted request books the memory until a known edge;
  // effects (grant, strobes, later read return) are scheduled by edge number.
  logic [7:0] ref_mem [64];
  int         cyc, free_at, rv_edge;
  bit         rv_pend, rv_port, m_last, win;
  logic [7:0] rv_val;
  logic       m_gc, m_gd, m_rd, m_wr, m_rvc, m_rvd, m_busy;
  logic [5:0] m_addr;
  logic [7:0] m_wdata, m_rdc, m_rdd, m_cnt;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 7 + 3);
    cyc = 0; free_at = 0; rv_edge = 0; rv_pend = 0; rv_port = 0; rv_val = '0; m_last = 1;
    {m_gc, m_gd, m_rd, m_wr, m_rvc, m_rvd, m_busy} = '0;
    m_addr = '0; m_wdata = '0; m_rdc = '0; m_rdd = '0; m_cnt = '0; win = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        {m_gc, m_gd, m_rd, m_wr, m_rvc, m_rvd, m_busy} = '0;
        m_addr = '0; m_wdata = '0; m_rdc = '0; m_rdd = '0; m_cnt = '0;
        m_last = 1; free_at = 0; rv_pend = 0;
      end else begin
        {m_gc, m_gd, m_rd, m_wr, m_rvc, m_rvd} = '0;
        if (rv_pend && rv_edge == cyc) begin
          if (rv_port) begin m_rvd = 1; m_rdd = rv_val; end
          else         begin m_rvc = 1; m_rdc = rv_val; end
          rv_pend = 0;
        end
        if (cyc >= free_at && (c_req || d_req)) begin
          if (c_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = !m_last;
`else
            win = 0;
`endif
            m_cnt = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
          end else begin
            win = d_req;
          end
          m_last = win;
          m_gc = !win; m_gd = win;
          m_addr  = win ? d_addr : c_addr;
          m_wdata = win ? d_wdata : c_wdata;
          if (win ? d_we : c_we) begin
            m_wr = 1;
            ref_mem[m_addr] = m_wdata;
            free_at = cyc + 2;
          end else begin
            m_rd = 1;
            rv_pend = 1; rv_port = win; rv_val = ref_mem[m_addr]; rv_edge = cyc + 2;
            free_at = cyc + 3;
          end
        end
        m_busy = (cyc < free_at - 1);
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("c_gnt",        32'(c_gnt),        32'(m_gc));
      chk("d_gnt",        32'(d_gnt),        32'(m_gd));
      chk("c_rvalid",     32'(c_rvalid),     32'(m_rvc));
      chk("d_rvalid",     32'(d_rvalid),     32'(m_rvd));
      chk("c_rdata",      32'(c_rdata),      32'(m_rdc));
      chk("d_rdata",      32'(d_rdata),      32'(m_rdd));
      chk("mem_read",     32'(mem_read),     32'(m_rd));
      chk("mem_write",    32'(mem_write),    32'(m_wr));
      chk("mem_addr",     32'(mem_addr),     32'(m_addr));
      chk("mem_wdata",    32'(mem_wdata),    32'(m_wdata));
      chk("busy",         32'(busy),         32'(m_busy));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end
  end

  task automatic wait_gnt(input bit port, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? d_gnt : c_gnt) && n < 50);
    if (port) chk("d_gnt seen", 32'(d_gnt), 32'h1);
    else      chk("c_gnt seen", 32'(c_gnt), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    {c_req, c_we, d_req, d_we} = '0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  int n, g;
  bit seq [8];

  initial begin
    reset_n = 1;
    {c_req, c_we, d_req, d_we} = '0;
    c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;
    #1 reset_n = 0;
    #2;
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset conflict_cnt", 32'(conflict_cnt), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1;

    // D write 0xA5 to 0x05, then C reads it back
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 6'h05; d_wdata = 8'hA5;
    wait_gnt(1, n);
    chk("t2 d_gnt latency", 32'(n), 32'd1);
    chk("t2 mem_write", 32'(mem_write), 32'h1);
    chk("t2 mem_addr", 32'(mem_addr), 32'h05);
    chk("t2 mem_wdata", 32'(mem_wdata), 32'hA5);
    d_req = 0; d_we = 0;
    c_req = 1; c_we = 0; c_addr = 6'h05;
    wait_gnt(0, n);
    chk("t2 c_gnt latency", 32'(n), 32'd2);
    chk("t2 mem_read", 32'(mem_read), 32'h1);
    c_req = 0;
    @(negedge clk);
    chk("t2 c_rvalid early", 32'(c_rvalid), 32'h0);
    @(negedge clk);
    chk("t2 c_rvalid", 32'(c_rvalid), 32'h1);
    chk("t2 c_rdata", 32'(c_rdata), 32'hA5);

    // D request arriving during C's ACCESS waits for IDLE
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 6'h07;
    wait_gnt(0, n);
    c_req = 0;
    d_req = 1; d_we = 0; d_addr = 6'h09;
    wait_gnt(1, n);
    chk("t6 d_gnt delay", 32'(n), 32'd3);
    d_req = 0;
    repeat (2) @(negedge clk);
    chk("t6 d_rvalid", 32'(d_rvalid), 32'h1);
    chk("t6 d_rdata", 32'(d_rdata), 32'h42);
    chk("t6 c_rdata kept", 32'(c_rdata), 32'h34);

    // Reset during RDWAIT: everything clears at once, no late rvalid
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 6'h05;
    wait_gnt(0, n);
    c_req = 0;
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("t1 busy", 32'(busy), 32'h0);
    chk("t1 c_rdata", 32'(c_rdata), 32'h0);
    chk("t1 d_rdata", 32'(d_rdata), 32'h0);
    chk("t1 mem_addr", 32'(mem_addr), 32'h0);
    chk("t1 mem_wdata", 32'(mem_wdata), 32'h0);
    chk("t1 c_rvalid", 32'(c_rvalid), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1 no rvalid", 32'(c_rvalid), 32'h0);
      chk("t1 idle", 32'(busy), 32'h0);
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Both ports read continuously: strict alternation starting with C
    do_reset();
    @(negedge clk);
    c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 6'h0A; d_addr = 6'h14;
    g = 0; n = 0;
    while (g < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (c_gnt || d_gnt) begin seq[g] = d_gnt; g++; end
    end
    c_req = 0; d_req = 0;
    chk("t3 grants", 32'(g), 32'd4);
    chk("t3 grant0 C", 32'(seq[0]), 32'h0);
    chk("t3 grant1 D", 32'(seq[1]), 32'h1);
    chk("t3 grant2 C", 32'(seq[2]), 32'h0);
    chk("t3 grant3 D", 32'(seq[3]), 32'h1);
    chk("t3 conflict_cnt", 32'(conflict_cnt), 32'd4);
    repeat (4) @(negedge clk);
`else
    // Fixed priority: C wins every conflict while it keeps requesting
    do_reset();
    @(negedge clk);
    c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 6'h0A; d_addr = 6'h14;
    g = 0; n = 0;
    while (g < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (c_gnt || d_gnt) begin seq[g] = d_gnt; g++; end
    end
    c_req = 0;
    chk("t4 grants", 32'(g), 32'd3);
    chk("t4 grant0 C", 32'(seq[0]), 32'h0);
    chk("t4 grant1 C", 32'(seq[1]), 32'h0);
    chk("t4 grant2 C", 32'(seq[2]), 32'h0);
    chk("t4 conflict_cnt", 32'(conflict_cnt), 32'd3);
    wait_gnt(1, n);
    d_req = 0;
    chk("t4 conflict_cnt after D", 32'(conflict_cnt), 32'd3);
    repeat (4) @(negedge clk);
`endif

    // 300 back-to-back write conflicts: counter saturates at 0xFF
    do_reset();
    @(negedge clk);
    c_req = 1; d_req = 1; c_we = 1; d_we = 1;
    c_addr = 6'h01; d_addr = 6'h02; c_wdata = 8'h11; d_wdata = 8'h22;
    g = 0; n = 0;
    while (g < 300 && n < 1000) begin
      @(negedge clk);
      n++;
      if (c_gnt || d_gnt) begin
        g++;
        if (g == 254) chk("t5 cnt at 254", 32'(conflict_cnt), 32'hFE);
        if (g == 255) chk("t5 cnt at 255", 32'(conflict_cnt), 32'hFF);
      end
    end
    c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    chk("t5 conflicts", 32'(g), 32'd300);
    chk("t5 cnt saturated", 32'(conflict_cnt), 32'hFF);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
